// File: rtl/vga_timing_pkg.sv
// Shared raster-timing constants and types for the scope display front end.
// The defaults describe the 1280x1024 mode; the top takes them as parameter defaults.
package vga_timing_pkg;
   localparam int COORD_W = 12;

   localparam int H_ACTIVE_DEF     = 1280;
   localparam int H_FP_DEF         = 48;
   localparam int H_SYNC_DEF       = 112;
   localparam int H_BP_DEF         = 248;
   localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;

   localparam int V_ACTIVE_DEF     = 1024;
   localparam int V_FP_DEF         = 1;
   localparam int V_SYNC_DEF       = 3;
   localparam int V_BP_DEF         = 38;
   localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

   // Bit order here is the bit order through the delay line.
   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
   } sync_t;

   function automatic logic in_window(input logic [COORD_W-1:0] c, input int lo, input int hi);
      return (int'(c) >= lo) && (int'(c) < hi);
   endfunction
endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register that retimes sync/active to the colour pipeline.
// DEPTH=0 collapses to a wire so q follows d in the same cycle.
module vga_delay_line #(
   parameter int               WIDTH   = 3,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   generate
      if (DEPTH == 0) begin : g_bypass
         logic w_unused;
         assign w_unused = &{1'b0, CLK, RESETn, en};
         assign q = d;
      end else begin : g_shift
         logic [DEPTH-1:0][WIDTH-1:0] r_stage;

         always_ff @(posedge CLK) begin
            if (!RESETn) begin
               r_stage <= {DEPTH{RST_VAL}};
            end else if (en) begin
               r_stage[0] <= d;
               for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
         end

         assign q = r_stage[DEPTH-1];
      end
   endgenerate
endmodule

// File: rtl/vga_coord_gen.sv
// Raster timing: pixel-tick divider, h/v counters, aligned decode and
// a tick-rate delay line for HS/VS/active feeding the colour pipeline.
module vga_coord_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int PIX_DIV  = 1,
   parameter int PIPE_DLY = 2
) (
   input  logic               CLK,
   input  logic               RESETn,
   output logic               VGA_pixTick,
   output logic [COORD_W-1:0] VGA_horzCoord,
   output logic [COORD_W-1:0] VGA_vertCoord,
   output logic               VGA_active,
   output logic               VGA_frameStart,
   output logic               VGA_lineStart,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_activeDly
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);

   logic [DIV_W-1:0]   r_div;
   logic               r_started;
   logic               r_pixTick;
   logic               r_active;
   logic               r_lineStart;
   logic               r_frameStart;
   logic [COORD_W-1:0] r_h;
   logic [COORD_W-1:0] r_v;
   logic [COORD_W-1:0] w_h_nxt;
   logic [COORD_W-1:0] w_v_nxt;
   logic               w_wrap;
   logic               w_h_last;
   sync_t              w_raw;
   sync_t              w_dly;

   assign w_wrap   = (r_div == DIV_LAST);
   assign w_h_last = (r_h == H_LAST);

   // The first tick after reset only arms the counters, so (0,0) is shown for a full tick.
   always_comb begin
      w_h_nxt = r_h;
      w_v_nxt = r_v;
      if (r_started) begin
         w_h_nxt = w_h_last ? '0 : r_h + 1'b1;
         if (w_h_last) w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_div        <= '0;
         r_started    <= 1'b0;
         r_pixTick    <= 1'b0;
         r_h          <= '0;
         r_v          <= '0;
         r_active     <= 1'b0;
         r_lineStart  <= 1'b0;
         r_frameStart <= 1'b0;
      end else begin
         r_div        <= w_wrap ? '0 : r_div + 1'b1;
         r_pixTick    <= w_wrap;
         r_lineStart  <= 1'b0;
         r_frameStart <= 1'b0;
         if (w_wrap) begin
            r_started    <= 1'b1;
            r_h          <= w_h_nxt;
            r_v          <= w_v_nxt;
            r_active     <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
            r_lineStart  <= r_started && (w_h_nxt == '0);
            r_frameStart <= r_started && (w_h_nxt == '0) && (w_v_nxt == '0);
         end
      end
   end

   always_comb begin
      w_raw.hs     = in_window(r_h, HS_START, HS_END) ? HS_POL : ~HS_POL;
      w_raw.vs     = in_window(r_v, VS_START, VS_END) ? VS_POL : ~VS_POL;
      w_raw.active = r_active;
   end

   vga_delay_line #(
      .WIDTH  (3),
      .DEPTH  (PIPE_DLY),
      .RST_VAL({~HS_POL, ~VS_POL, 1'b0})
   ) u_dly (
      .CLK   (CLK),
      .RESETn(RESETn),
      .en    (r_pixTick),
      .d     (w_raw),
      .q     (w_dly)
   );

   assign VGA_pixTick    = r_pixTick;
   assign VGA_horzCoord  = r_h;
   assign VGA_vertCoord  = r_v;
   assign VGA_active     = r_active;
   assign VGA_frameStart = r_frameStart;
   assign VGA_lineStart  = r_lineStart;
   assign VGA_HS         = w_dly.hs;
   assign VGA_VS         = w_dly.vs;
   assign VGA_activeDly  = w_dly.active;
endmodule

// File: tb/tb_vga_coord_gen.sv
// Bench for vga_coord_gen: one full-size instance plus three small-raster
// instances (PIX_DIV/PIPE_DLY/polarity variants) against a closed-form model.
module tb_vga_coord_gen;
   localparam int SHA = 20, SHF = 3, SHS = 4, SHB = 5;
   localparam int SVA = 10, SVF = 1, SVS = 3, SVB = 2;
   localparam int NI  = 4;

   typedef struct packed {
      logic        pix;
      logic [11:0] h;
      logic [11:0] v;
      logic        act;
      logic        fs;
      logic        ls;
      logic        hs;
      logic        vs;
      logic        actd;
   } obs_t;

   typedef struct {
      int ha, hf, hsy, hb, va, vf, vsy, vb, pd, dly;
      bit hpol, vpol;
   } cfg_t;

   typedef struct {
      int n, h, v;
      bit ls, hs, actd, act;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b0;
   logic        pt[NI], ac[NI], fs[NI], ls[NI], hs[NI], vs[NI], ad[NI];
   logic [11:0] hc[NI], vc[NI];

   int   checks = 0;
   int   failures = 0;
   int   edge_n = 0;
   bit   chk_en = 1'b0;
   cfg_t cfgs[NI];
   vec_t tbl[14];
   obs_t e_o, a_o;

   always #5 CLK = ~CLK;

   vga_coord_gen #(.PIX_DIV(1), .PIPE_DLY(2)) u_big (
      .CLK(CLK), .RESETn(RESETn), .VGA_pixTick(pt[0]), .VGA_horzCoord(hc[0]),
      .VGA_vertCoord(vc[0]), .VGA_active(ac[0]), .VGA_frameStart(fs[0]),
      .VGA_lineStart(ls[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_activeDly(ad[0]));

   vga_coord_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                   .HS_POL(1'b0), .VS_POL(1'b1), .PIX_DIV(1), .PIPE_DLY(2)) u_sm (
      .CLK(CLK), .RESETn(RESETn), .VGA_pixTick(pt[1]), .VGA_horzCoord(hc[1]),
      .VGA_vertCoord(vc[1]), .VGA_active(ac[1]), .VGA_frameStart(fs[1]),
      .VGA_lineStart(ls[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_activeDly(ad[1]));

   vga_coord_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                   .HS_POL(1'b0), .VS_POL(1'b1), .PIX_DIV(1), .PIPE_DLY(0)) u_sm0 (
      .CLK(CLK), .RESETn(RESETn), .VGA_pixTick(pt[2]), .VGA_horzCoord(hc[2]),
      .VGA_vertCoord(vc[2]), .VGA_active(ac[2]), .VGA_frameStart(fs[2]),
      .VGA_lineStart(ls[2]), .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_activeDly(ad[2]));

   vga_coord_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                   .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(4), .PIPE_DLY(2)) u_sm4 (
      .CLK(CLK), .RESETn(RESETn), .VGA_pixTick(pt[3]), .VGA_horzCoord(hc[3]),
      .VGA_vertCoord(vc[3]), .VGA_active(ac[3]), .VGA_frameStart(fs[3]),
      .VGA_lineStart(ls[3]), .VGA_HS(hs[3]), .VGA_VS(vs[3]), .VGA_activeDly(ad[3]));

   // Tick t>=1 shows raster pixel t-1; tick 0 is the reset/idle picture.
   function automatic void pix_at(input cfg_t c, input int t, output int h, output int v,
                                  output bit act, output bit hsl, output bit vsl);
      int ht, vt;
      ht = c.ha + c.hf + c.hsy + c.hb;
      vt = c.va + c.vf + c.vsy + c.vb;
      h = (t == 0) ? 0 : (t - 1) % ht;
      v = (t == 0) ? 0 : ((t - 1) / ht) % vt;
      act = (t > 0) && (h < c.ha) && (v < c.va);
      hsl = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsy) ? c.hpol : ~c.hpol;
      vsl = (v >= c.va + c.vf && v < c.va + c.vf + c.vsy) ? c.vpol : ~c.vpol;
   endfunction

   // n = CLK edges seen with reset released since the last reset edge.
   function automatic obs_t model(input cfg_t c, input int n);
      obs_t o;
      int   t, td, h, v, h2, v2;
      bit   act, hsl, vsl, act2;
      t = n / c.pd;
      pix_at(c, t, h, v, act, hsl, vsl);
      o.pix = (n > 0) && (n % c.pd == 0);
      o.h   = 12'(h);
      o.v   = 12'(v);
      o.act = act;
      o.ls  = o.pix && (t >= 2) && (h == 0);
      o.fs  = o.ls && (v == 0);
      // Delay line samples once per tick cycle, i.e. on the edge after each tick.
      if (c.dly == 0) td = t;
      else td = (n == 0) ? 0 : (n - 1) / c.pd - c.dly + 1;
      if (td < 0) td = 0;
      pix_at(c, td, h2, v2, act2, hsl, vsl);
      o.hs   = hsl;
      o.vs   = vsl;
      o.actd = act2;
      return o;
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   always @(posedge CLK) edge_n <= RESETn ? edge_n + 1 : 0;

   always @(negedge CLK) begin
      if (chk_en) begin
         for (int k = 0; k < NI; k++) begin
            e_o = model(cfgs[k], edge_n);
            a_o = {pt[k], hc[k], vc[k], ac[k], fs[k], ls[k], hs[k], vs[k], ad[k]};
            checks++;
            if (a_o !== e_o) begin
               failures++;
               $display("FAIL sb inst%0d n=%0d got=%h exp=%h", k, edge_n, a_o, e_o);
            end
         end
      end
   end

   initial begin
      int guard, cnt, c_act, c_actd, c_fs, c_ls, c_hs, c_vs, c_pix;
      cfgs[0] = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1, 2, 1'b1, 1'b1};
      cfgs[1] = '{SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1, 2, 1'b0, 1'b1};
      cfgs[2] = '{SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1, 0, 1'b0, 1'b1};
      cfgs[3] = '{SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 4, 2, 1'b1, 1'b1};
      //            n     h     v  ls hs actd act
      tbl[0]  = '{   1,    0,   0, 0, 0, 0, 1};
      tbl[1]  = '{   2,    1,   0, 0, 0, 0, 1};
      tbl[2]  = '{   3,    2,   0, 0, 0, 1, 1};
      tbl[3]  = '{1280, 1279,   0, 0, 0, 1, 1};
      tbl[4]  = '{1281, 1280,   0, 0, 0, 1, 0};
      tbl[5]  = '{1282, 1281,   0, 0, 0, 1, 0};
      tbl[6]  = '{1283, 1282,   0, 0, 0, 0, 0};
      tbl[7]  = '{1330, 1329,   0, 0, 0, 0, 0};
      tbl[8]  = '{1331, 1330,   0, 0, 1, 0, 0};
      tbl[9]  = '{1442, 1441,   0, 0, 1, 0, 0};
      tbl[10] = '{1443, 1442,   0, 0, 0, 0, 0};
      tbl[11] = '{1688, 1687,   0, 0, 0, 0, 0};
      tbl[12] = '{1689,    0,   1, 1, 0, 0, 1};
      tbl[13] = '{1690,    1,   1, 0, 0, 0, 1};

      RESETn = 1'b0;
      @(posedge CLK);
      chk_en = 1'b1;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      chk("reset_coords", {hc[0], vc[0]}, 0);
      chk("reset_hs_vs_actd", {hs[0], vs[0], ad[0], hs[1], pt[0]}, 5'b00010);
      RESETn = 1'b1;

      foreach (tbl[i]) begin
         guard = 0;
         while (edge_n < tbl[i].n && guard < 5000) begin @(negedge CLK); guard++; end
         chk($sformatf("tbl_n%0d", tbl[i].n),
             {hc[0], vc[0], ls[0], hs[0], ad[0], ac[0]},
             {12'(tbl[i].h), 12'(tbl[i].v), tbl[i].ls, tbl[i].hs, tbl[i].actd, tbl[i].act});
      end

      // PIPE_DLY 0 vs 2 at the frame's first visible pixel
      guard = 0;
      while (!fs[1] && guard < 2000) begin @(negedge CLK); guard++; end
      chk("fs_seen_sm", fs[1], 1);
      chk("dly0_follows", {ac[2], ad[2]}, 2'b11);
      chk("dly2_tick0", ad[1], 0);
      @(negedge CLK);
      chk("dly2_tick1", ad[1], 0);
      @(negedge CLK);
      chk("dly2_tick2", ad[1], 1);

      // One whole small frame, counted from just after a frameStart
      guard = 0;
      while (!fs[1] && guard < 2000) begin @(negedge CLK); guard++; end
      chk("fs_seen_sm2", fs[1], 1);
      {c_act, c_actd, c_fs, c_ls, c_hs, c_vs} = '0;
      repeat (32 * 16) begin
         @(negedge CLK);
         c_act += int'(ac[1]); c_actd += int'(ad[1]); c_fs += int'(fs[1]);
         c_ls += int'(ls[1]); c_hs += int'(!hs[1]); c_vs += int'(vs[1]);
      end
      chk("frame_fs_count", c_fs, 1);
      chk("frame_fs_at_end", fs[1], 1);
      chk("frame_active", c_act, SHA * SVA);
      chk("frame_activeDly", c_actd, SHA * SVA);
      chk("frame_lines", c_ls, 16);
      chk("frame_hs_ticks", c_hs, SHS * 16);
      chk("frame_vs_ticks", c_vs, SVS * 32);

      // PIX_DIV=4 line length
      guard = 0;
      while (!ls[3] && guard < 2000) begin @(negedge CLK); guard++; end
      chk("ls_seen_div4", ls[3], 1);
      cnt = 0; c_pix = 0;
      do begin @(negedge CLK); cnt++; c_pix += int'(pt[3]); end while (!ls[3] && cnt < 1000);
      chk("div4_line_clk", cnt, 32 * 4);
      chk("div4_line_ticks", c_pix, 32);

      // One-cycle reset in mid-frame
      guard = 0;
      while (!(hc[1] == 12'd10 && vc[1] == 12'd5) && guard < 2000) begin @(negedge CLK); guard++; end
      chk("mid_pos_reached", {hc[1], vc[1]}, {12'd10, 12'd5});
      RESETn = 1'b0;
      @(negedge CLK);
      RESETn = 1'b1;
      chk("mid_rst_coords", {hc[1], vc[1], hc[0], vc[0]}, 0);
      chk("mid_rst_dly", {hs[1], vs[1], ad[1], pt[1], ac[1]}, 5'b10000);
      @(negedge CLK);
      chk("mid_first_tick", {hc[1], vc[1], ac[1], fs[1], ls[1]}, {24'd0, 3'b100});
      @(negedge CLK);
      chk("mid_second_tick", hc[1], 1);

      // Random run lengths and reset pulses; the scoreboard checks every cycle
      repeat (6) begin
         repeat ($urandom_range(3000, 20)) @(negedge CLK);
         RESETn = 1'b0;
         repeat ($urandom_range(3, 1)) @(negedge CLK);
         RESETn = 1'b1;
      end
      repeat (600) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog expired at t=%0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
